// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory access path.
// Holds the access-size encoding, the mem_access FSM state encoding and the
// default bus timeout used by mem_access.
package mips_pkg;

  // Access size as carried on ex_Size.
  typedef enum logic [1:0] {
    SizeByte    = 2'b00,
    SizeHalf    = 2'b01,
    SizeWord    = 2'b10,
    SizeIllegal = 2'b11
  } size_e;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // Cycles a BUSY access waits for dmem_ack before reporting a bus error.
  localparam int unsigned DefaultTimeout = 16;

endpackage

// File: rtl/mem_load_align.sv
// Load-lane extraction for mem_access.
// Picks the addressed byte/half out of a little-endian read word, right-justifies
// it and sign- or zero-extends it to S bits. Words pass through unchanged.
//   rdata_i    : word returned by data memory
//   ofs_i      : byte offset (address bits [1:0]) of the access
//   size_i     : access size
//   unsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o     : aligned load result
module mem_load_align
  import mips_pkg::*;
#(
  parameter int unsigned S = 32
) (
  input  logic [S-1:0] rdata_i,
  input  logic [1:0]   ofs_i,
  input  size_e        size_i,
  input  logic         unsigned_i,
  output logic [S-1:0] data_o
);

  logic [S-1:0] shifted;

  always_comb begin
    shifted = rdata_i >> {ofs_i, 3'b000};
    data_o  = rdata_i;
    case (size_i)
      SizeByte: data_o = {{(S-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
      SizeHalf: data_o = {{(S-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access controller.
// Decodes loads/stores from the EX/MEM register, stalls the pipeline while a bus
// access is outstanding, and returns an aligned load result with one-cycle
// valid/misalign/bus-error pulses.
//   clk, reset              : clock, asynchronous active-low reset
//   ex_*                    : EX/MEM instruction fields
//   stall_out               : hold EX/MEM and upstream stages
//   dmem_*                  : data-memory request/response bus
//   mem_ReadData, mem_valid : result to mem_wb
//   mem_misalign, mem_buserr: error pulses accompanying mem_valid
module mem_access
  import mips_pkg::*;
#(
  parameter int unsigned S       = 32,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ex_valid,
  input  logic         ex_MemRead,
  input  logic         ex_MemWrite,
  input  logic [1:0]   ex_Size,
  input  logic         ex_Unsigned,
  input  logic [S-1:0] ex_Addr,
  input  logic [S-1:0] ex_WriteData,
  output logic         stall_out,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [S-1:0] dmem_addr,
  output logic [3:0]   dmem_be,
  output logic [S-1:0] dmem_wdata,
  input  logic         dmem_ack,
  input  logic [S-1:0] dmem_rdata,
  output logic [S-1:0] mem_ReadData,
  output logic         mem_valid,
  output logic         mem_misalign,
  output logic         mem_buserr
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      ofs_q;
  size_e           size_q;
  logic            uns_q;
  logic            load_q;

  logic            mem_op, misalign_chk, illegal, start, timeout_hit, done;
  logic [3:0]      be_calc;
  logic [S-1:0]    wdata_calc;
  logic [S-1:0]    load_data;

  // Size/alignment only matter when the instruction actually touches memory.
  always_comb begin
    mem_op = ex_valid & (ex_MemRead ^ ex_MemWrite);
    misalign_chk = 1'b0;
    be_calc      = 4'b1111;
    wdata_calc   = ex_WriteData;
    case (ex_Size)
      SizeByte: begin
        be_calc    = 4'b0001 << ex_Addr[1:0];
        wdata_calc = {(S/8){ex_WriteData[7:0]}};
      end
      SizeHalf: begin
        misalign_chk = ex_Addr[0];
        be_calc      = ex_Addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc   = {(S/16){ex_WriteData[15:0]}};
      end
      SizeWord: misalign_chk = |ex_Addr[1:0];
      default:  misalign_chk = 1'b1;
    endcase
    illegal = ex_valid & ((ex_MemRead & ex_MemWrite) |
                          ((ex_MemRead | ex_MemWrite) & misalign_chk));
    start       = (state_q == StIdle) & mem_op & ~illegal;
    timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
    // An ack in the timeout cycle wins over the timeout.
    done        = (state_q == StBusy) & (dmem_ack | timeout_hit);
    // The stall releases in the completing cycle so EX/MEM advances as the result lands.
    stall_out   = start | ((state_q == StBusy) & ~done);
  end

  mem_load_align #(
    .S(S)
  ) u_load_align (
    .rdata_i   (dmem_rdata),
    .ofs_i     (ofs_q),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .data_o    (load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ofs_q        <= '0;
      size_q       <= SizeByte;
      uns_q        <= 1'b0;
      load_q       <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      mem_ReadData <= '0;
      mem_valid    <= 1'b0;
      mem_misalign <= 1'b0;
      mem_buserr   <= 1'b0;
    end else begin
      mem_valid    <= 1'b0;
      mem_misalign <= 1'b0;
      mem_buserr   <= 1'b0;
      mem_ReadData <= '0;
      case (state_q)
        StIdle: begin
          if (illegal) begin
            mem_valid    <= 1'b1;
            mem_misalign <= 1'b1;
          end else if (start) begin
            state_q    <= StBusy;
            cnt_q      <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= ex_MemWrite;
            dmem_addr  <= {ex_Addr[S-1:2], 2'b00};
            dmem_be    <= be_calc;
            dmem_wdata <= wdata_calc;
            ofs_q      <= ex_Addr[1:0];
            size_q     <= size_e'(ex_Size);
            uns_q      <= ex_Unsigned;
            load_q     <= ex_MemRead;
          end else if (ex_valid) begin
            mem_valid <= 1'b1;
          end
        end
        StBusy: begin
          if (done) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            mem_valid  <= 1'b1;
            if (dmem_ack) begin
              mem_ReadData <= load_q ? load_data : '0;
            end else begin
              mem_buserr <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0, ex_MemRead = 1'b0, ex_MemWrite = 1'b0;
  logic [1:0]  ex_Size = 2'b00;
  logic        ex_Unsigned = 1'b0;
  logic [31:0] ex_Addr = '0, ex_WriteData = '0;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] mem_ReadData;
  logic        mem_valid, mem_misalign, mem_buserr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access #(
    .S      (32),
    .TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_MemRead  (ex_MemRead),
    .ex_MemWrite (ex_MemWrite),
    .ex_Size     (ex_Size),
    .ex_Unsigned (ex_Unsigned),
    .ex_Addr     (ex_Addr),
    .ex_WriteData(ex_WriteData),
    .stall_out   (stall_out),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .mem_ReadData(mem_ReadData),
    .mem_valid   (mem_valid),
    .mem_misalign(mem_misalign),
    .mem_buserr  (mem_buserr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rres;
    logic        mis;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];
  vec_t v;
  int   cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    ex_valid = 1'b1; ex_MemRead = rd; ex_MemWrite = wr; ex_Size = size;
    ex_Unsigned = uns; ex_Addr = addr; ex_WriteData = wd;
  endtask

  initial begin
    //            rd wr size  uns addr          wd            rdata         be       wdata         rres          mis
    vecs[0]  = '{1, 0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 0};
    vecs[1]  = '{1, 0, 2'b00, 0, 32'h103, 32'h0,        32'h80FFFFFF, 4'b1000, 32'h0,        32'hFFFFFF80, 0};
    vecs[2]  = '{1, 0, 2'b00, 1, 32'h103, 32'h0,        32'h80FFFFFF, 4'b1000, 32'h0,        32'h00000080, 0};
    vecs[3]  = '{0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 4'b1100, 32'hABCDABCD, 32'h0,        0};
    vecs[4]  = '{0, 1, 2'b00, 0, 32'h101, 32'h000000A5, 32'h12345678, 4'b0010, 32'hA5A5A5A5, 32'h0,        0};
    vecs[5]  = '{0, 1, 2'b10, 0, 32'h104, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0,        0};
    vecs[6]  = '{1, 0, 2'b01, 0, 32'h102, 32'h0,        32'h80011234, 4'b1100, 32'h0,        32'hFFFF8001, 0};
    vecs[7]  = '{1, 0, 2'b01, 1, 32'h100, 32'h0,        32'h1234F00D, 4'b0011, 32'h0,        32'h0000F00D, 0};
    vecs[8]  = '{1, 0, 2'b00, 0, 32'h101, 32'h0,        32'h11227F44, 4'b0010, 32'h0,        32'h0000007F, 0};
    vecs[9]  = '{1, 0, 2'b10, 0, 32'h101, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1};
    vecs[10] = '{1, 0, 2'b01, 0, 32'h103, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1};
    vecs[11] = '{1, 1, 2'b10, 0, 32'h100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1};
    vecs[12] = '{1, 0, 2'b11, 0, 32'h100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1};

    // Reset state
    #2;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_rdata", mem_ReadData, 0);
    #10 reset = 1'b1;
    tick();

    // Table-driven single-access vectors, ack in the first BUSY cycle
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      set_op(v.rd, v.wr, v.size, v.uns, v.addr, v.wd);
      #1;
      chk($sformatf("v%0d_stall0", i), stall_out, !v.mis);
      chk($sformatf("v%0d_req0", i), dmem_req, 0);
      if (v.mis) begin
        tick();
        ex_valid = 1'b0;
        #1;
        chk($sformatf("v%0d_valid", i), mem_valid, 1);
        chk($sformatf("v%0d_misalign", i), mem_misalign, 1);
        chk($sformatf("v%0d_rdata", i), mem_ReadData, 0);
        chk($sformatf("v%0d_noreq", i), dmem_req, 0);
        chk($sformatf("v%0d_buserr", i), mem_buserr, 0);
      end else begin
        tick();
        ex_valid = 1'b0;
        chk($sformatf("v%0d_req", i), dmem_req, 1);
        chk($sformatf("v%0d_we", i), dmem_we, v.wr);
        chk($sformatf("v%0d_be", i), dmem_be, v.be);
        chk($sformatf("v%0d_wdata", i), dmem_wdata, v.wdata);
        chk($sformatf("v%0d_addr", i), dmem_addr, v.addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_valid_busy", i), mem_valid, 0);
        dmem_ack = 1'b1;
        dmem_rdata = v.rdata;
        #1;
        chk($sformatf("v%0d_stall_ack", i), stall_out, 0);
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        chk($sformatf("v%0d_valid", i), mem_valid, 1);
        chk($sformatf("v%0d_rdata", i), mem_ReadData, v.rres);
        chk($sformatf("v%0d_misalign", i), mem_misalign, 0);
        chk($sformatf("v%0d_buserr", i), mem_buserr, 0);
        chk($sformatf("v%0d_req_done", i), dmem_req, 0);
      end
      tick();
      chk($sformatf("v%0d_valid_pulse", i), mem_valid, 0);
    end

    // Load word with two wait cycles: three stall cycles, one valid cycle
    cnt = 0;
    set_op(1, 0, 2'b10, 0, 32'h100, 32'h0);
    #1;
    if (stall_out) cnt++;
    tick();
    ex_valid = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (stall_out) cnt++;
      chk("lw2_req_held", dmem_req, 1);
      chk("lw2_be_held", dmem_be, 4'b1111);
      tick();
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    if (stall_out) cnt++;
    chk("lw2_stall_count", cnt, 3);
    tick();
    dmem_ack = 1'b0;
    chk("lw2_valid", mem_valid, 1);
    chk("lw2_rdata", mem_ReadData, 32'hDEADBEEF);
    tick();
    chk("lw2_valid_once", mem_valid, 0);

    // Non-memory instruction: no stall, plain valid
    set_op(0, 0, 2'b10, 0, 32'h101, 32'h0);
    #1;
    chk("nop_stall", stall_out, 0);
    tick();
    ex_valid = 1'b0;
    chk("nop_valid", mem_valid, 1);
    chk("nop_flags", {mem_misalign, mem_buserr}, 0);
    chk("nop_req", dmem_req, 0);
    chk("nop_rdata", mem_ReadData, 0);
    tick();

    // Timeout without ack
    set_op(1, 0, 2'b10, 0, 32'h200, 32'h0);
    tick();
    ex_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && dmem_req; i++) begin
      cnt++;
      tick();
    end
    chk("to_busy_cycles", cnt, 16);
    chk("to_req_dropped", dmem_req, 0);
    chk("to_valid", mem_valid, 1);
    chk("to_buserr", mem_buserr, 1);
    chk("to_rdata", mem_ReadData, 0);
    tick();
    chk("to_buserr_pulse", mem_buserr, 0);

    // Ack in the 16th BUSY cycle counts as success
    set_op(1, 0, 2'b10, 0, 32'h300, 32'h0);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("ack16_req", dmem_req, 1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0BADF00D;
    tick();
    dmem_ack = 1'b0;
    chk("ack16_valid", mem_valid, 1);
    chk("ack16_buserr", mem_buserr, 0);
    chk("ack16_rdata", mem_ReadData, 32'h0BADF00D);
    tick();

    // Reset in the middle of BUSY; late ack must be ignored
    set_op(0, 1, 2'b10, 0, 32'h400, 32'h55AA55AA);
    tick();
    ex_valid = 1'b0;
    tick();
    chk("rb_req_before", dmem_req, 1);
    reset = 1'b0;
    #1;
    chk("rb_req", dmem_req, 0);
    chk("rb_stall", stall_out, 0);
    chk("rb_be", dmem_be, 0);
    chk("rb_wdata", dmem_wdata, 0);
    #10 reset = 1'b1;
    dmem_ack = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_valid || dmem_req) cnt++;
    end
    dmem_ack = 1'b0;
    chk("rb_late_ack_ignored", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
